// File: rtl/sccb_cfg_master.sv
// sccb_cfg_master
//   SCCB configuration master for OmniVision-class sensors. It sequences the
//   sensor power-up pins, then walks an external {reg,value} table issuing
//   3-phase SCCB writes. It also performs on-demand register readback
//   (2-phase write followed by 2-phase read), honours in-table delay entries,
//   and reports NACKs.
//
// Ports
//   clk, rst             system clock, asynchronous active-high reset
//   start                pulse: run the table from entry 0 (IDLE only)
//   rd_req, rd_reg       pulse + address: read one sensor register (IDLE only)
//   rd_data, rd_valid    read result and its one-cycle strobe
//   busy, done           not-in-IDLE level; table-completed level
//   nack_err             sticky: a write ACK slot was sampled high
//   tbl_addr, tbl_data   table index out; registered {reg,value} back one cycle later
//   sioc, siod_oe, siod_out, siod_in   SCCB pins (tristate is built above this block)
//   cam_rst_n, cam_pwdn, cam_xclk      sensor control pins
module sccb_cfg_master #(
  parameter int unsigned QTICK       = 25,
  parameter int unsigned XCLK_HALF   = 1,
  parameter logic [7:0]  DEV_ID      = 8'h42,
  parameter int unsigned TBL_AW      = 6,
  parameter int unsigned RST_CYCLES  = 10000,
  parameter int unsigned WAIT_CYCLES = 10000,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rd_req,
  input  logic [7:0]        rd_reg,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              nack_err,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              sioc,
  output logic              siod_oe,
  output logic              siod_out,
  input  logic              siod_in,
  output logic              cam_rst_n,
  output logic              cam_pwdn,
  output logic              cam_xclk
);

  localparam logic [3:0] S_RST_HOLD = 4'd0;
  localparam logic [3:0] S_SETTLE   = 4'd1;
  localparam logic [3:0] S_IDLE     = 4'd2;
  localparam logic [3:0] S_FETCH    = 4'd3;
  localparam logic [3:0] S_WR       = 4'd4;
  localparam logic [3:0] S_DLY      = 4'd5;
  localparam logic [3:0] S_FIN      = 4'd6;
  localparam logic [3:0] S_RD_W     = 4'd7;
  localparam logic [3:0] S_RD_R     = 4'd8;
  localparam logic [3:0] S_STOP     = 4'd9;
  localparam logic [3:0] S_GAP      = 4'd10;

  // Which transaction STOP/GAP belong to
  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_RDW = 2'd1;
  localparam logic [1:0] K_RDR = 2'd2;

  localparam int CMAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int QW   = (QTICK > 1) ? $clog2(QTICK) : 1;
  localparam int XW   = (XCLK_HALF > 1) ? $clog2(XCLK_HALF) : 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [QW-1:0] Q_LAST    = QW'(QTICK - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(XCLK_HALF - 1);

  logic [3:0]    state;
  logic [CW-1:0] cnt;
  logic          fcnt;
  logic [QW-1:0] qcnt;
  logic [1:0]    qtr;     // quarter within the current bit / START / STOP / GAP
  logic          stb;     // bit states: still inside the START unit
  logic [3:0]    bpos;    // bit within byte, 8 = 9th (ACK/NA) bit
  logic [1:0]    bidx;    // byte within phase
  logic [1:0]    xk;
  logic [7:0]    wreg, wval, rreg, rsh;
  logic [XW-1:0] xcnt;

  logic          bus_st, bit_st, tick, q_end, smp;
  logic [1:0]    last_b;
  logic [7:0]    cur_byte;
  logic          tx_bit;
  logic          nx_sioc, nx_oe, nx_sdo;

  assign bit_st = (state == S_WR) || (state == S_RD_W) || (state == S_RD_R);
  assign bus_st = bit_st || (state == S_STOP) || (state == S_GAP);
  assign tick   = bus_st && (qcnt == Q_LAST);
  assign q_end  = tick && (qtr == 2'd3);
  // Sample on the tick that enters Q2 of a data bit
  assign smp    = tick && (qtr == 2'd1) && bit_st && !stb;
  assign last_b = (xk == K_WR) ? 2'd2 : 2'd1;
  assign busy   = (state != S_IDLE);
  assign cam_pwdn = 1'b0;

  always_comb begin
    cur_byte = DEV_ID;
    if (bidx == 2'd1)      cur_byte = (xk == K_RDW) ? rreg : wreg;
    else if (bidx == 2'd2) cur_byte = wval;
    else if (xk == K_RDR)  cur_byte = DEV_ID | 8'h01;
  end
  assign tx_bit = cur_byte[3'd7 - bpos[2:0]];

  // Pin levels for the current bus position; registered below so the pins
  // never see decode glitches (they trail the state by one cycle).
  always_comb begin
    nx_sioc = 1'b1;
    nx_oe   = 1'b0;
    nx_sdo  = 1'b1;
    if (bit_st) begin
      if (stb) begin
        nx_oe   = 1'b1;
        nx_sdo  = (qtr == 2'd0);
        nx_sioc = ~qtr[1];
      end else begin
        nx_sioc = qtr[1];
        if (bpos == 4'd8) begin
          // Master drives NA=1 after the read byte; otherwise slave's slot
          if (xk == K_RDR && bidx == 2'd1) nx_oe = 1'b1;
        end else if (!(xk == K_RDR && bidx == 2'd1)) begin
          nx_oe  = 1'b1;
          nx_sdo = tx_bit;
        end
      end
    end else if (state == S_STOP) begin
      nx_oe   = 1'b1;
      nx_sioc = (qtr != 2'd0);
      nx_sdo  = qtr[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sioc     <= 1'b1;
      siod_oe  <= 1'b0;
      siod_out <= 1'b1;
    end else begin
      sioc     <= nx_sioc;
      siod_oe  <= nx_oe;
      siod_out <= nx_sdo;
    end
  end

  // XCLK free-runs from the first cycle after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xcnt     <= '0;
      cam_xclk <= 1'b0;
    end else if (xcnt == X_LAST) begin
      xcnt     <= '0;
      cam_xclk <= ~cam_xclk;
    end else begin
      xcnt <= xcnt + XW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RST_HOLD;
      cnt       <= '0;
      fcnt      <= 1'b0;
      qcnt      <= '0;
      qtr       <= '0;
      stb       <= 1'b0;
      bpos      <= '0;
      bidx      <= '0;
      xk        <= K_WR;
      wreg      <= '0;
      wval      <= '0;
      rreg      <= '0;
      rsh       <= '0;
      tbl_addr  <= '0;
      done      <= 1'b0;
      nack_err  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      cam_rst_n <= 1'b0;
    end else begin
      rd_valid <= 1'b0;

      // Quarter-tick timebase restarts on entry so bus edges align to ticks
      if (!bus_st) begin
        qcnt <= '0;
        qtr  <= '0;
      end else if (tick) begin
        qcnt <= '0;
        qtr  <= qtr + 2'd1;
      end else begin
        qcnt <= qcnt + QW'(1);
      end

      if (smp) begin
        if (state == S_WR && bpos == 4'd8 && siod_in) nack_err <= 1'b1;
        if (state == S_RD_R && bidx == 2'd1 && bpos != 4'd8) rsh <= {rsh[6:0], siod_in};
      end

      case (state)
        S_RST_HOLD: begin
          if (cnt == RST_LAST) begin
            cnt       <= '0;
            cam_rst_n <= 1'b1;
            state     <= S_SETTLE;
          end else cnt <= cnt + CW'(1);
        end
        S_SETTLE: begin
          if (cnt == RST_LAST) begin
            cnt   <= '0;
            state <= AUTO_START ? S_FETCH : S_IDLE;
          end else cnt <= cnt + CW'(1);
        end
        S_IDLE: begin
          // start has priority; a simultaneous rd_req is dropped
          if (start) begin
            done     <= 1'b0;
            nack_err <= 1'b0;
            tbl_addr <= '0;
            state    <= S_FETCH;
          end else if (rd_req) begin
            rreg  <= rd_reg;
            xk    <= K_RDW;
            stb   <= 1'b1;
            bpos  <= '0;
            bidx  <= '0;
            state <= S_RD_W;
          end
        end
        S_FETCH: begin
          // tbl_data reflects tbl_addr on the second FETCH cycle
          if (!fcnt) fcnt <= 1'b1;
          else begin
            fcnt <= 1'b0;
            if (tbl_data == 16'hFFFF) state <= S_FIN;
            else if (tbl_data == 16'hFFF0) begin
              cnt   <= '0;
              state <= S_DLY;
            end else begin
              wreg  <= tbl_data[15:8];
              wval  <= tbl_data[7:0];
              xk    <= K_WR;
              stb   <= 1'b1;
              bpos  <= '0;
              bidx  <= '0;
              state <= S_WR;
            end
          end
        end
        S_DLY: begin
          if (cnt == WAIT_LAST) begin
            cnt <= '0;
            if (&tbl_addr) state <= S_FIN;
            else begin
              tbl_addr <= tbl_addr + TBL_AW'(1);
              state    <= S_FETCH;
            end
          end else cnt <= cnt + CW'(1);
        end
        S_WR, S_RD_W, S_RD_R: begin
          if (q_end) begin
            if (stb) stb <= 1'b0;
            else if (bpos == 4'd8) begin
              bpos <= '0;
              if (bidx == last_b) state <= S_STOP;
              else bidx <= bidx + 2'd1;
            end else bpos <= bpos + 4'd1;
          end
        end
        S_STOP: if (q_end) state <= S_GAP;
        S_GAP: begin
          if (q_end) begin
            case (xk)
              K_WR: begin
                if (&tbl_addr) state <= S_FIN;
                else begin
                  tbl_addr <= tbl_addr + TBL_AW'(1);
                  state    <= S_FETCH;
                end
              end
              K_RDW: begin
                xk    <= K_RDR;
                stb   <= 1'b1;
                bpos  <= '0;
                bidx  <= '0;
                state <= S_RD_R;
              end
              default: begin
                rd_data  <= rsh;
                rd_valid <= 1'b1;
                state    <= S_IDLE;
              end
            endcase
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_RST_HOLD;
      endcase
    end
  end

endmodule

// File: doc/sccb_cfg_master.md
# sccb_cfg_master

Parametrised SCCB configuration master for OmniVision-class camera sensors, the next generation of our OV7670 bring-up controller. It sequences the camera power-up pins (reset, power-down, XCLK), then walks an external register table of address/value pairs and issues 3-phase SCCB writes. Beyond the current controller, it supports on-demand 2-phase-write plus 2-phase-read register readback, in-table delay entries, NACK reporting, and generic bus timing and table depth. It sits between the system fabric and the sensor pins; the top level builds the SIOD tristate from `siod_oe`/`siod_out`.

## Interface
- QTICK, 25: clk cycles per SCCB quarter-bit; 25 gives 100 kHz SIOC at 10 MHz clk.
- XCLK_HALF, 1: clk cycles per XCLK half-period.
- DEV_ID, 8'h42: SCCB write ID; the read ID is DEV_ID|1.
- TBL_AW, 6: table address width; depth is 2^TBL_AW.
- RST_CYCLES, 10000: cycles that cam_rst_n is held low, then the settle time after release.
- WAIT_CYCLES, 10000: stall length for a delay entry.
- AUTO_START, 1: run the table automatically after power-up sequencing.
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse: run the table from entry 0
- rd_req  in  1  pulse: read register rd_reg
- rd_reg  in  8  register address for a read
- rd_data  out  8  read result
- rd_valid  out  1  one-cycle pulse when rd_data updates
- busy  out  1  high whenever the master is not in IDLE
- done  out  1  table completed; level signal
- nack_err  out  1  sticky: a write ACK slot was sampled high
- tbl_addr  out  TBL_AW  table index
- tbl_data  in  16  {reg, value}; registered, valid one cycle after tbl_addr
- sioc  out  1  SCCB clock
- siod_oe, siod_out  out  1  SIOD drive enable and drive value
- siod_in  in  1  SIOD pin value
- cam_rst_n, cam_pwdn, cam_xclk  out  1  sensor control pins

## Operation
- **States:** RST_HOLD → SETTLE → (AUTO_START ? FETCH : IDLE); IDLE → FETCH on start, → RD_W on rd_req; FETCH → WR / DLY / FIN; WR, RD_W, RD_R → STOP → GAP; DLY → FETCH.
- **Power-up sequence:**
  - RST_HOLD: cam_rst_n=0 for RST_CYCLES.
  - SETTLE: cam_rst_n=1 for RST_CYCLES.
  - cam_pwdn is held 0 throughout.
  - cam_xclk toggles every XCLK_HALF cycles from the first cycle after reset and never stops.
- **FETCH:**
  - Drive tbl_addr and wait 2 cycles for tbl_data.
  - Entry 16'hFFFF → FIN.
  - Entry 16'hFFF0 → DLY, which stalls WAIT_CYCLES and then moves to the next entry.
  - Otherwise → WR.
- **WR:** START, then 3 bytes (DEV_ID, reg, value) MSB first, each followed by a 9th don't-care bit with siod_oe=0.
  - siod_in is sampled in the 9th bit's Q2.
  - A sample of 1 sets nack_err; the sequence continues regardless.
- **Table end:**
  - After the entry at index 2^TBL_AW−1, go to FIN.
  - FIN sets done and returns to IDLE.
- **RD_W:** START, DEV_ID, rd_reg, STOP, GAP.
- **RD_R:** START, DEV_ID|1, then 8 bits with siod_oe=0, each sampled in Q2. Master then drives the 9th bit as NA=1, then STOP.
  - rd_data is loaded and rd_valid pulses on the GAP→IDLE cycle.
- **Request arbitration:**
  - start and rd_req are accepted only in IDLE; while busy they are ignored, not queued.
  - If both arrive in the same cycle, start wins and rd_req is dropped.
  - Accepting start clears done and nack_err.
- **Reset:** rst at any time, including mid-byte, forces the reset values immediately and restarts at RST_HOLD. The bus is left released: sioc=1, siod_oe=0.
- **Reset values:**
  - sioc=1, siod_oe=0, siod_out=1
  - cam_rst_n=0, cam_pwdn=0, cam_xclk=0
  - busy=1, done=0, nack_err=0
  - rd_valid=0, rd_data=0, tbl_addr=0

## Timing
- **Quarter ticks:** every QTICK cycles; all bus edges align to tick boundaries.
- **Data bit (4 ticks):**
  - Q0: sioc=0, siod updates.
  - Q1: sioc=0.
  - Q2: sioc=1, sample taken on entry.
  - Q3: sioc=1.
- **START (4 ticks):** siod=1/sioc=1, then siod=0, then sioc=0.
- **STOP (4 ticks):** siod=0/sioc=0, then sioc=1, then siod=1.
- **GAP:** 4 ticks idle-high.
- **Write transaction:** 4+108+4+4 = 120 ticks (3000 cycles at defaults), plus 2 fetch cycles.
- **Read transaction:** 2-phase write 84 ticks, plus read phase 84 ticks, total 168 ticks, then rd_valid.

## Test plan
- **Power-up:**
  - Stimulus: reset, RST_CYCLES=20, AUTO_START=0.
  - Response: cam_rst_n low for exactly 20 cycles; busy falls 40 cycles after reset release; cam_xclk period 2·XCLK_HALF.
- **Table write:**
  - Stimulus: table {12 80, FFF0, 11 01, FFFF}, QTICK=2, bus model ACKs.
  - Response: two SCCB writes decoded as 42/12/80 and 42/11/01, separated by ≥WAIT_CYCLES; done=1; nack_err=0.
- **NACK:**
  - Stimulus: model holds SIOD high in the 2nd ACK slot.
  - Response: nack_err=1 and stays 1 through done; the next start clears it.
- **Readback:**
  - Stimulus: rd_req with rd_reg=0A; model returns 76.
  - Response: bus shows 42/0A STOP, then 43 followed by the read; NA=1; rd_data=76 with a single-cycle rd_valid.
- **Collision:**
  - Stimulus: start and rd_req in the same IDLE cycle.
  - Response: the table runs; no read transaction occurs.
  - Stimulus: rd_req during busy.
  - Response: ignored.
- **Reset mid-byte:**
  - Stimulus: rst asserted in bit 5 of the reg byte.
  - Response: sioc=1, siod_oe=0, cam_rst_n=0 in the same cycle; the sequence restarts from RST_HOLD.
